// File: rtl/shared_unit_arbiter_pkg.sv
// Shared definitions for the shared arithmetic-unit arbiter: FSM encoding and default sizes.
package shared_unit_arbiter_pkg;

  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefW    = 16;
  localparam int unsigned DefToW  = 18;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StResp  = 3'd3;
  localparam logic [2:0] StFault = 3'd4;

endpackage

// File: rtl/shared_unit_arbiter_if.sv
// Requester and shared-unit signals of the arbiter; master is the arbiter, slave the environment.
interface shared_unit_arbiter_if
  import shared_unit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned W    = DefW
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_grant;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              u_start;
  logic [W-1:0]      u_a;
  logic [W-1:0]      u_b;
  logic              u_ready;
  logic [W-1:0]      u_y;
  logic              busy;
  logic              fault;

  modport master (
    input  req_valid, req_a, req_b, u_ready, u_y,
    output req_grant, rsp_valid, rsp_data, rsp_err, u_start, u_a, u_b, busy, fault
  );

  modport slave (
    output req_valid, req_a, req_b, u_ready, u_y,
    input  req_grant, rsp_valid, rsp_data, rsp_err, u_start, u_a, u_b, busy, fault
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request scanning ptr, ptr+1, ... modulo NREQ.
module rr_priority_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            any_o,
  output logic [IW-1:0]   idx_o
);

  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    // Scan from the farthest offset down so the one nearest ptr is written last and wins.
    for (int off = int'(NREQ) - 1; off >= 0; off--) begin
      if (req_i[(int'(ptr_i) + off) % NREQ]) begin
        idx_o = IW'((int'(ptr_i) + off) % NREQ);
      end
    end
  end

endmodule

// File: rtl/shared_unit_arbiter.sv
// Round-robin sequencer sharing one start/ready arithmetic unit among NREQ requesters,
// with a watchdog that latches a sticky fault when the unit never answers.
module shared_unit_arbiter
  import shared_unit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned W    = DefW,
  parameter int unsigned TO_W = DefToW
) (
  input logic                   clk,
  input logic                   rst,
  shared_unit_arbiter_if.master bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TO_W-1:0] WdLast = {{(TO_W-1){1'b1}}, 1'b0};

  logic [2:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [W-1:0]    u_a_q, u_a_d, u_b_q, u_b_d;
  logic            u_start_q, u_start_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            fault_q, fault_d;
  logic            busy_q, busy_d;

  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [W-1:0]    opa [NREQ];
  logic [W-1:0]    opb [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign opa[i] = bus.req_a[i*W +: W];
    assign opb[i] = bus.req_b[i*W +: W];
  end

  rr_priority_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wd_d        = wd_q;
    u_a_d       = u_a_q;
    u_b_d       = u_b_q;
    u_start_d   = 1'b0;
    grant_d     = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    fault_d     = fault_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          u_a_d             = opa[pick_idx];
          u_b_d             = opb[pick_idx];
          grant_d[pick_idx] = 1'b1;
          u_start_d         = 1'b1;
          owner_d           = pick_idx;
          state_d           = StIssue;
        end
      end
      // u_ready is not looked at here so a sticky ready from the last op cannot complete this one.
      StIssue: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.u_ready) begin
          rsp_data_d           = bus.u_y;
          rsp_err_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = StResp;
        end else if (wd_q == WdLast) begin
          wd_d                 = '1;
          rsp_data_d           = '0;
          rsp_err_d            = 1'b1;
          fault_d              = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = StResp;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      StResp: begin
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
        state_d = fault_q ? StFault : StIdle;
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      wd_q        <= '0;
      u_a_q       <= '0;
      u_b_q       <= '0;
      u_start_q   <= 1'b0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      fault_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wd_q        <= wd_d;
      u_a_q       <= u_a_d;
      u_b_q       <= u_b_d;
      u_start_q   <= u_start_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      fault_q     <= fault_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_grant = grant_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.u_start   = u_start_q;
  assign bus.u_a       = u_a_q;
  assign bus.u_b       = u_b_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Self-checking bench: adder / sticky shift-add multiplier unit models, response scoreboard,
// and a second arbiter with a short watchdog whose unit never answers.
module tb_shared_unit_arbiter;
  import shared_unit_arbiter_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 16;
  localparam int ModeAdd = 0;
  localparam int ModeMul = 1;

  typedef struct {
    int          mode;
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] y;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mode   = ModeAdd;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  shared_unit_arbiter_if #(.NREQ(NREQ), .W(W)) bus0 ();
  shared_unit_arbiter_if #(.NREQ(NREQ), .W(W)) bus1 ();

  shared_unit_arbiter #(.NREQ(NREQ), .W(W), .TO_W(18)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  shared_unit_arbiter #(.NREQ(NREQ), .W(W), .TO_W(4)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Unit model: 1-cycle pulsed adder, or shift-add multiplier whose ready stays up until next start.
  logic [15:0] m_acc, m_cand, m_plier;
  logic        m_run;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus0.u_ready <= 1'b0;
      bus0.u_y     <= '0;
      m_acc        <= '0;
      m_cand       <= '0;
      m_plier      <= '0;
      m_run        <= 1'b0;
    end else if (mode == ModeAdd) begin
      bus0.u_ready <= bus0.u_start;
      if (bus0.u_start) bus0.u_y <= bus0.u_a + bus0.u_b;
      m_run <= 1'b0;
    end else if (bus0.u_start) begin
      m_acc        <= '0;
      m_cand       <= bus0.u_a;
      m_plier      <= bus0.u_b;
      m_run        <= 1'b1;
      bus0.u_ready <= 1'b0;
    end else if (m_run) begin
      if (m_plier == 16'd0) begin
        bus0.u_ready <= 1'b1;
        bus0.u_y     <= m_acc;
        m_run        <= 1'b0;
      end else begin
        if (m_plier[0]) m_acc <= m_acc + m_cand;
        m_cand  <= m_cand << 1;
        m_plier <= m_plier >> 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus0.rsp_valid != '0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b, required none", bus0.rsp_valid);
      end else begin
        e = sb_q.pop_front();
        check("rsp_owner", 32'(bus0.rsp_valid), 32'(1) << e.id);
        check("rsp_data", 32'(bus0.rsp_data), 32'(e.y));
        check("rsp_err", 32'(bus0.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic drive_req(input int id, input logic [15:0] a, input logic [15:0] b);
    bus0.req_a[id*16 +: 16] = a;
    bus0.req_b[id*16 +: 16] = b;
    bus0.req_valid[id]      = 1'b1;
  endtask

  task automatic wait_grant(input int id);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (bus0.req_grant != '0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant, required grant to %0d", id);
    end else begin
      check("grant_id", 32'(bus0.req_grant), 32'(1) << id);
    end
  endtask

  task automatic wait_rsp(input int id);
    bit seen = 1'b0;
    for (int n = 0; n < 80 && !seen; n++) begin
      @(negedge clk);
      if (bus0.rsp_valid[id]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid, required rsp to %0d", id);
    end
  endtask

  task automatic run_vec(input vec_t v);
    mode = v.mode;
    drive_req(v.id, v.a, v.b);
    sb_q.push_back('{v.id, v.y, 1'b0});
    wait_grant(v.id);
    bus0.req_valid[v.id] = 1'b0;
    wait_rsp(v.id);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, 32'(bus0.req_grant), 0);
    check({tag, "_rsp_valid"}, 32'(bus0.rsp_valid), 0);
    check({tag, "_rsp_data"}, 32'(bus0.rsp_data), 0);
    check({tag, "_rsp_err"}, 32'(bus0.rsp_err), 0);
    check({tag, "_u_start"}, 32'(bus0.u_start), 0);
    check({tag, "_u_a"}, 32'(bus0.u_a), 0);
    check({tag, "_u_b"}, 32'(bus0.u_b), 0);
    check({tag, "_busy"}, 32'(bus0.busy), 0);
    check({tag, "_fault"}, 32'(bus0.fault), 0);
  endtask

  task automatic do_reset();
    bus0.req_valid = '0;
    bus1.req_valid = '0;
    rst = 1'b1;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish within bound");
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    int   order [8];
    int   cnt;
    bit   seen;

    vecs[0] = '{ModeAdd, 1, 16'd100,    16'd23,     16'd123};
    vecs[1] = '{ModeAdd, 2, 16'hFFFF,   16'h0001,   16'h0000};
    vecs[2] = '{ModeAdd, 3, 16'h1234,   16'h4321,   16'h5555};
    vecs[3] = '{ModeAdd, 0, 16'h8000,   16'h7FFF,   16'hFFFF};
    vecs[4] = '{ModeMul, 0, 16'd5,      16'd9,      16'd45};
    vecs[5] = '{ModeMul, 2, 16'd2,      16'd3,      16'd6};
    vecs[6] = '{ModeMul, 3, 16'h0100,   16'h0100,   16'h0000};
    vecs[7] = '{ModeAdd, 1, 16'd7,      16'd8,      16'd15};
    order   = '{0, 1, 2, 3, 0, 1, 2, 3};

    bus0.req_valid = '0;
    bus0.req_a = '0;
    bus0.req_b = '0;
    bus1.req_valid = '0;
    bus1.req_a = '0;
    bus1.req_b = '0;
    bus1.u_ready = 1'b0;
    bus1.u_y = 16'hBEEF;
    #2 rst = 1'b1;
    @(negedge clk);
    check_zero("reset");
    check("reset_dut_to_fault", 32'(bus1.fault), 0);
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // Single adder op: grant one edge after the request, response three edges after.
    @(posedge clk);
    #1;
    drive_req(0, 16'd3, 16'd4);
    sb_q.push_back('{0, 16'd7, 1'b0});
    @(negedge clk);
    check("t1_no_early_grant", 32'(bus0.req_grant), 0);
    @(negedge clk);
    check("t1_grant", 32'(bus0.req_grant), 32'h1);
    check("t1_u_start", 32'(bus0.u_start), 1);
    check("t1_u_a", 32'(bus0.u_a), 3);
    check("t1_u_b", 32'(bus0.u_b), 4);
    check("t1_busy", 32'(bus0.busy), 1);
    bus0.req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_u_start_drop", 32'(bus0.u_start), 0);
    check("t1_grant_drop", 32'(bus0.req_grant), 0);
    check("t1_no_early_rsp", 32'(bus0.rsp_valid), 0);
    @(negedge clk);
    check("t1_rsp_latency", 32'(bus0.rsp_valid), 32'h1);
    @(negedge clk);
    check("t1_rsp_pulse", 32'(bus0.rsp_valid), 0);
    check("t1_idle", 32'(bus0.busy), 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // All four requesters held: rotation 0,1,2,3 then each re-requests once more.
    do_reset();
    mode = ModeAdd;
    for (int i = 0; i < 4; i++) begin
      drive_req(i, 16'(10 * i + 1), 16'(i + 200));
      sb_q.push_back('{i, 16'(11 * i + 201), 1'b0});
    end
    for (int k = 0; k < 8; k++) begin
      wait_grant(order[k]);
      bus0.req_valid[order[k]] = 1'b0;
      wait_rsp(order[k]);
      if (k < 4) begin
        drive_req(order[k], 16'(1000 + k), 16'(k));
        sb_q.push_back('{order[k], 16'(1000 + 2 * k), 1'b0});
      end
    end
    @(negedge clk);

    // Unit operands must hold while the requester operands toggle every cycle.
    mode = ModeMul;
    drive_req(1, 16'h0123, 16'h0011);
    sb_q.push_back('{1, 16'h1353, 1'b0});
    wait_grant(1);
    bus0.req_valid[1] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge clk);
      #1;
      bus0.req_a = ~bus0.req_a;
      bus0.req_b = ~bus0.req_b;
      @(negedge clk);
      if (bus0.rsp_valid[1]) seen = 1'b1;
      else begin
        check("t4_u_a_hold", 32'(bus0.u_a), 32'h0123);
        check("t4_u_b_hold", 32'(bus0.u_b), 32'h0011);
      end
    end
    check("t4_rsp_seen", 32'(seen), 1);
    @(negedge clk);

    // Short-watchdog instance: unit never answers.
    @(posedge clk);
    #1;
    bus1.req_a[2*16 +: 16] = 16'h1111;
    bus1.req_b[2*16 +: 16] = 16'h2222;
    bus1.req_valid[2] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus1.req_grant != '0) seen = 1'b1;
    end
    check("t5_grant", 32'(bus1.req_grant), 32'h4);
    bus1.req_valid[2] = 1'b0;
    cnt = 0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      cnt++;
      if (bus1.rsp_valid != '0) seen = 1'b1;
    end
    check("t5_timeout_cycles", 32'(cnt), 16);
    check("t5_rsp_owner", 32'(bus1.rsp_valid), 32'h4);
    check("t5_rsp_err", 32'(bus1.rsp_err), 1);
    check("t5_rsp_data", 32'(bus1.rsp_data), 0);
    check("t5_fault", 32'(bus1.fault), 1);
    bus1.req_valid = 4'b1011;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("t5_no_grant", 32'(bus1.req_grant), 0);
      check("t5_no_start", 32'(bus1.u_start), 0);
    end
    check("t5_fault_sticky", 32'(bus1.fault), 1);
    check("t5_busy", 32'(bus1.busy), 1);

    // Asynchronous reset mid-WAIT, then ptr must be back at 0.
    mode = ModeMul;
    drive_req(3, 16'h00AA, 16'hFFFF);
    sb_q.push_back('{3, 16'h0000, 1'b0});
    wait_grant(3);
    bus0.req_valid[3] = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_busy_before", 32'(bus0.busy), 1);
    bus1.req_valid = '0;
    #2 rst = 1'b1;
    #1;
    check_zero("t6_async");
    check("t6_dut_to_fault", 32'(bus1.fault), 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    mode = ModeAdd;
    drive_req(1, 16'd40, 16'd2);
    drive_req(2, 16'd50, 16'd5);
    sb_q.push_back('{1, 16'd42, 1'b0});
    sb_q.push_back('{2, 16'd55, 1'b0});
    wait_grant(1);
    bus0.req_valid[1] = 1'b0;
    wait_rsp(1);
    wait_grant(2);
    bus0.req_valid[2] = 1'b0;
    wait_rsp(2);
    repeat (2) @(negedge clk);

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
